// File: rtl/stream_stride_permutation.sv
// Streaming stride / bit-reversal permutation of N-point frames through a ping-pong frame store.
// Optional feature macro: NTT_PERM_BITREV_EN (honours perm_mode and adds the bit-reversal index path).
module stream_stride_permutation #(
  parameter int DATA_WIDTH_PER_INPUT = 32,
  parameter int INPUT_PER_CYCLE      = 32,
  parameter int N                    = 512,
  parameter int STRIDE               = 2
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            in_start,
  input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] inData,
  input  logic                                            perm_mode,
  output logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] outData,
  output logic                                            out_valid,
  output logic                                            out_start
);

  localparam int W    = DATA_WIDTH_PER_INPUT;
  localparam int P    = INPUT_PER_CYCLE;
  localparam int F    = N / P;
  localparam int LOGN = $clog2(N);
  localparam int LOGF = $clog2(F);
  localparam int LOGM = LOGN - $clog2(STRIDE);
  localparam logic [LOGF-1:0] LAST_BEAT = LOGF'(F - 1);

  typedef enum logic { W_IDLE, W_FILL  } w_state_t;
  typedef enum logic { R_IDLE, R_DRAIN } r_state_t;

  logic [W-1:0]    mem [2][N];
  w_state_t        w_state, w_state_next;
  r_state_t        r_state, r_state_next;
  logic [LOGF-1:0] wc, wc_next, rc, rc_next;
  logic            wr_bank, wr_bank_next, rd_bank, rd_bank_next;
  logic [1:0]      full, full_next;
  logic            do_write, w_done, emit, r_done;
  logic [LOGN-1:0] rd_idx, src_idx;
  logic [P*W-1:0]  rd_data;

  // With N/S a power of two, (j mod N/S)*S + j/(N/S) is a rotation of the index bits.
  function automatic logic [LOGN-1:0] stride_src(input logic [LOGN-1:0] j);
    return {j[LOGM-1:0], j[LOGN-1:LOGM]};
  endfunction

`ifdef NTT_PERM_BITREV_EN
  logic [1:0] bank_mode;

  function automatic logic [LOGN-1:0] bit_rev(input logic [LOGN-1:0] j);
    logic [LOGN-1:0] r;
    for (int b = 0; b < LOGN; b++) r[b] = j[LOGN-1-b];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) bank_mode <= '0;
    else if (w_state == W_IDLE && in_start) bank_mode[wr_bank] <= perm_mode;
  end
`else
  // Stride-only build: perm_mode is accepted on the port but has no effect.
  logic perm_mode_unused;
  assign perm_mode_unused = perm_mode;
`endif

  always_comb begin
    w_state_next = w_state;
    wc_next      = wc;
    wr_bank_next = wr_bank;
    do_write     = 1'b0;
    w_done       = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (in_start) begin
          do_write     = 1'b1;
          wc_next      = LOGF'(1);
          w_state_next = W_FILL;
        end
      end
      W_FILL: begin
        do_write = 1'b1;
        if (wc == LAST_BEAT) begin
          w_done       = 1'b1;
          wc_next      = '0;
          wr_bank_next = ~wr_bank;
          w_state_next = W_IDLE;
        end else begin
          wc_next = wc + 1'b1;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // Beat 0 of a drain is issued the first cycle its bank shows full, even from R_IDLE.
  always_comb begin
    emit         = (r_state == R_DRAIN) || full[rd_bank];
    r_done       = emit && (rc == LAST_BEAT);
    rc_next      = rc;
    rd_bank_next = rd_bank;
    r_state_next = R_IDLE;
    if (emit) begin
      r_state_next = R_DRAIN;
      if (r_done) begin
        rc_next      = '0;
        rd_bank_next = ~rd_bank;
        r_state_next = full[~rd_bank] ? R_DRAIN : R_IDLE;
      end else begin
        rc_next = rc + 1'b1;
      end
    end
  end

  always_comb begin
    full_next = full;
    if (r_done) full_next[rd_bank] = 1'b0;
    if (w_done) full_next[wr_bank] = 1'b1;
  end

  always_comb begin
    rd_data = '0;
    rd_idx  = '0;
    src_idx = '0;
    for (int k = 0; k < P; k++) begin
      rd_idx  = LOGN'(int'(rc) * P + k);
      src_idx = stride_src(rd_idx);
`ifdef NTT_PERM_BITREV_EN
      if (bank_mode[rd_bank]) src_idx = bit_rev(rd_idx);
`endif
      rd_data[k*W +: W] = mem[rd_bank][src_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && !rst) begin
      for (int k = 0; k < P; k++) mem[wr_bank][LOGN'(int'(wc) * P + k)] <= inData[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      wc        <= '0;
      rc        <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      outData   <= '0;
      out_valid <= 1'b0;
      out_start <= 1'b0;
    end else begin
      w_state   <= w_state_next;
      r_state   <= r_state_next;
      wc        <= wc_next;
      rc        <= rc_next;
      wr_bank   <= wr_bank_next;
      rd_bank   <= rd_bank_next;
      full      <= full_next;
      out_valid <= emit;
      out_start <= emit && (rc == '0);
      if (emit) outData <= rd_data;
    end
  end

endmodule

// File: tb/tb_stream_stride_permutation.sv
// Bench for stream_stride_permutation: directed test-plan scenarios plus random frames vs a frame-level model.
// Bit-reversal expectations apply only when NTT_PERM_BITREV_EN is defined.
module tb_stream_stride_permutation;

  localparam int W    = 32;
  localparam int P    = 32;
  localparam int N    = 512;
  localparam int S    = 2;
  localparam int F    = N / P;
  localparam int BW   = P * W;
  localparam int MAXC = 4096;
  localparam int LOGN = $clog2(N);

  logic          clk = 1'b0;
  logic          rst, in_start, perm_mode, out_valid, out_start;
  logic [BW-1:0] inData, outData;

  stream_stride_permutation #(
    .DATA_WIDTH_PER_INPUT(W), .INPUT_PER_CYCLE(P), .N(N), .STRIDE(S)
  ) dut (
    .clk(clk), .rst(rst), .in_start(in_start), .inData(inData),
    .perm_mode(perm_mode), .outData(outData), .out_valid(out_valid), .out_start(out_start)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  int            n = 0;
  bit            exp_valid [MAXC];
  bit            exp_start [MAXC];
  logic [BW-1:0] exp_data  [MAXC];
  logic [BW-1:0] last_out = '0;
  bit            filling = 1'b0;
  bit            fill_mode;
  int            fill_t0, fill_cnt;
  logic [W-1:0]  fill_buf [N];
  int            valid_cnt;
  int            start_q[$];
  logic [BW-1:0] cap [F];
  int            cap_idx;

  typedef struct { int beat; int lane; int value; } spot_t;
  spot_t stride_tab [7];
  spot_t brev_tab   [4];

  // Source element of output position j, straight from the permutation definitions.
  function automatic int src_of(int j, bit mode);
    int r = 0;
    if (mode) begin
      for (int b = 0; b < LOGN; b++)
        if (((j >> b) & 1) != 0) r |= 1 << (LOGN - 1 - b);
      return r;
    end
    return (j % (N / S)) * S + j / (N / S);
  endfunction

  task automatic schedule(input int t0, input bit mode);
    logic [BW-1:0] v;
    for (int b = 0; b < F; b++) begin
      int c = t0 + F + 1 + b;
      for (int k = 0; k < P; k++) v[k*W +: W] = fill_buf[src_of(b * P + k, mode)];
      if (c < MAXC) begin
        exp_valid[c] = 1'b1;
        exp_start[c] = (b == 0);
        exp_data[c]  = v;
      end
    end
  endtask

  task automatic check_eq(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic check_output();
    bit            ev, es;
    logic [BW-1:0] ed;
    ev = exp_valid[n];
    es = exp_start[n];
    ed = ev ? exp_data[n] : last_out;
    if (ev) last_out = ed;
    checks++;
    if (out_valid !== ev) begin
      errors++;
      $display("[TB] FAIL out_valid cyc=%0d actual=%b expected=%b", n, out_valid, ev);
    end
    checks++;
    if (out_start !== es) begin
      errors++;
      $display("[TB] FAIL out_start cyc=%0d actual=%b expected=%b", n, out_start, es);
    end
    checks++;
    if (outData !== ed) begin
      errors++;
      for (int k = 0; k < P; k++) begin
        if (outData[k*W +: W] !== ed[k*W +: W]) begin
          $display("[TB] FAIL outData cyc=%0d lane=%0d actual=%h expected=%h",
                   n, k, outData[k*W +: W], ed[k*W +: W]);
          break;
        end
      end
    end
    if (out_start === 1'b1) begin
      cap_idx = 0;
      start_q.push_back(n);
    end
    if (out_valid === 1'b1) begin
      valid_cnt++;
      if (cap_idx < F) begin
        cap[cap_idx] = outData;
        cap_idx++;
      end
    end
  endtask

  // One clock cycle: check what the previous edge produced, then drive this cycle and update the model.
  task automatic apply_stimulus(input bit st, input bit md, input logic [BW-1:0] d, input bit r);
    if (n > 0 && n < MAXC) check_output();
    rst       = r;
    in_start  = st;
    perm_mode = md;
    inData    = d;
    if (r) begin
      filling = 1'b0;
      for (int c = n + 1; c < n + 2 * F + 4 && c < MAXC; c++) begin
        exp_valid[c] = 1'b0;
        exp_start[c] = 1'b0;
      end
      last_out = '0;
    end else if (filling || st) begin
      if (!filling) begin
        filling  = 1'b1;
        fill_t0  = n;
        fill_cnt = 0;
`ifdef NTT_PERM_BITREV_EN
        fill_mode = md;
`else
        fill_mode = 1'b0;
`endif
      end
      for (int k = 0; k < P; k++) fill_buf[fill_cnt * P + k] = d[k*W +: W];
      fill_cnt++;
      if (fill_cnt == F) begin
        filling = 1'b0;
        schedule(fill_t0, fill_mode);
      end
    end
    @(negedge clk);
    n++;
  endtask

  task automatic idle(input int m);
    for (int i = 0; i < m; i++) apply_stimulus(1'b0, 1'($urandom), '0, 1'b0);
  endtask

  task automatic run_frame(input int base, input bit mode, input int spur_at,
                           input int rst_at, input bit rnd);
    logic [BW-1:0] d;
    for (int c = 0; c < F; c++) begin
      for (int k = 0; k < P; k++) d[k*W +: W] = rnd ? $urandom : W'(base + c * P + k);
      if (c == rst_at) begin
        apply_stimulus(1'b0, mode, d, 1'b1);
        return;
      end
      apply_stimulus((c == 0) || (c == spur_at), (c == 0) ? mode : 1'($urandom), d, 1'b0);
    end
  endtask

  task automatic clear_obs();
    valid_cnt = 0;
    start_q.delete();
    cap_idx = F;
  endtask

  function automatic int get_start(input int i);
    return (start_q.size() > i) ? start_q[i] : -1;
  endfunction

  task automatic check_spots(input bit use_brev);
    if (use_brev) begin
      for (int i = 0; i < 4; i++)
        check_eq($sformatf("brev b%0d l%0d", brev_tab[i].beat, brev_tab[i].lane),
                 int'(cap[brev_tab[i].beat][brev_tab[i].lane*W +: W]), brev_tab[i].value);
    end else begin
      for (int i = 0; i < 7; i++)
        check_eq($sformatf("stride b%0d l%0d", stride_tab[i].beat, stride_tab[i].lane),
                 int'(cap[stride_tab[i].beat][stride_tab[i].lane*W +: W]), stride_tab[i].value);
    end
  endtask

  initial begin
    int t;
    stride_tab[0] = '{0, 0, 0};
    stride_tab[1] = '{0, 1, 2};
    stride_tab[2] = '{0, 31, 62};
    stride_tab[3] = '{1, 0, 64};
    stride_tab[4] = '{8, 0, 1};
    stride_tab[5] = '{8, 1, 3};
    stride_tab[6] = '{15, 31, 511};
    brev_tab[0]   = '{0, 0, 0};
    brev_tab[1]   = '{0, 1, 256};
    brev_tab[2]   = '{1, 0, 8};
    brev_tab[3]   = '{15, 31, 511};

    rst = 1'b1; in_start = 1'b0; perm_mode = 1'b0; inData = '0;
    clear_obs();
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    apply_stimulus(1'b0, 1'b0, '0, 1'b1);
    idle(3);

    clear_obs(); t = n;
    run_frame(0, 1'b0, -1, -1, 1'b0);
    idle(2 * F + 4);
    check_eq("stride start cycle", get_start(0), t + F + 1);
    check_eq("stride valid beats", valid_cnt, F);
    check_spots(1'b0);

    clear_obs(); t = n;
    run_frame(0, 1'b0, 5, -1, 1'b0);
    idle(2 * F + 4);
    check_eq("spurious start cycle", get_start(0), t + F + 1);
    check_eq("spurious valid beats", valid_cnt, F);
    check_spots(1'b0);

    clear_obs(); t = n;
    run_frame(0, 1'b1, -1, -1, 1'b0);
    idle(2 * F + 4);
    check_eq("mode1 start cycle", get_start(0), t + F + 1);
`ifdef NTT_PERM_BITREV_EN
    check_spots(1'b1);
`else
    check_spots(1'b0);
`endif

    clear_obs(); t = n;
    run_frame(0, 1'b0, -1, -1, 1'b0);
    run_frame(1000, 1'b0, -1, -1, 1'b0);
    idle(2 * F + 4);
    check_eq("b2b first start", get_start(0), t + F + 1);
    check_eq("b2b second start", get_start(1), t + 2 * F + 1);
    check_eq("b2b valid beats", valid_cnt, 2 * F);
    check_eq("b2b frame2 b0 l1", int'(cap[0][1*W +: W]), 1002);

    clear_obs(); t = n;
    run_frame(0, 1'b0, -1, 8, 1'b0);
    idle(3);
    run_frame(0, 1'b0, -1, -1, 1'b0);
    idle(2 * F + 4);
    check_eq("rst new frame start", get_start(0), t + 29);
    check_eq("rst start count", get_start(1), -1);
    check_eq("rst valid beats", valid_cnt, F);
    check_spots(1'b0);

    for (int f = 0; f < 40; f++) begin
      int spur, ra;
      idle($urandom_range(0, 3));
      spur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, F - 1) : -1;
      ra   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, F - 1) : -1;
      run_frame(0, 1'($urandom), spur, ra, 1'b1);
    end
    idle(2 * F + 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_stride_permutation.md
# stream_stride_permutation

Parametrised streaming permutation stage for the NTT pipeline: accepts an N-point frame arriving INPUT_PER_CYCLE words per cycle, buffers it in a ping-pong frame store, and emits it reordered by a stride permutation (or, optionally, bit-reversal). Unlike fixed intra-cycle lane swaps, it permutes across cycles as well as lanes, so it covers the inter-stage reorderings that span beats. It sits between butterfly stages and in front of the first stage as the input reorder.

## Interface
- DATA_WIDTH_PER_INPUT, 32, bits per coefficient
- INPUT_PER_CYCLE, 32, lanes per beat (P); power of two
- N, 512, points per frame; power of two, N/P >= 2
- STRIDE, 2, stride S of the permutation; power of two, 2 <= S <= N/2
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- in_start  input  1  pulse marking beat 0 of an input frame
- inData  input  P*DATA_WIDTH_PER_INPUT  packed lanes, lane k at [k*W +: W]
- perm_mode  input  1  0 = stride, 1 = bit-reversal; sampled with in_start
- outData  output  P*DATA_WIDTH_PER_INPUT  packed permuted lanes, registered
- out_valid  output  1  high on each of the F = N/P output beats
- out_start  output  1  pulse on output beat 0

## Operation
- Storage: two frame buffers of N words each (bank 0/1); contents not reset.
- Write FSM: W_IDLE -> W_FILL on in_start; beat counter wc 0..F-1; beat c lane k written to index c*P+k of write bank. After wc=F-1: mark bank full, toggle write bank, return to W_IDLE, or go straight to W_FILL with wc=0 if in_start is high that same next cycle.
- Input beats of a frame are contiguous; no input valid. in_start while in W_FILL is ignored.
- perm_mode latched per frame at in_start, stored with the bank.
- Read FSM: R_IDLE -> R_DRAIN when a bank is full; beat counter rc 0..F-1; output position j = rc*P+k takes source index:
  - stride: (j mod (N/S))*S + floor(j/(N/S))
  - bit-reversal: bitrev(j, log2 N)
- After rc=F-1: clear bank full, toggle read bank; continue R_DRAIN if other bank full, else R_IDLE.
- Index arithmetic: log2 N bits, unsigned, mod/div by powers of two as bit slices; no wrap beyond N.
- Overflow impossible: read drain F cycles equals fill F cycles, so a bank is always drained before refill.

## Timing
- Reset: outData=0, out_valid=0, out_start=0, both FSMs idle, wc=rc=0, bank pointers 0, full flags cleared.
- in_start at cycle t (beat 0): beats at t..t+F-1; read beat 0 computed at t+F; outData beat 0 with out_valid=1, out_start=1 at t+F+1. Latency F+1 cycles.
- out_valid high t+F+1..t+2F; outData holds last value when out_valid low.
- Back-to-back frames (in_start at t+F): out_valid continuous, out_start every F cycles.
- rst mid-frame: partial fill and pending drain discarded; outputs zero from next cycle; in_start in the first cycle after rst deasserts is accepted.
- in_start coincident with rst: ignored.

## Configuration
- NTT_PERM_BITREV_EN defined: perm_mode honoured; bit-reversal index path compiled in.
- Undefined: perm_mode port present but ignored; all frames use stride permutation; no bit-reversal logic.

## Test plan
N=512, P=32, W=32 (F=16), input element i carries value i, in_start at t.
- Stride S=2, perm_mode=0 -> out_start at t+17; beat 0 lanes = 0,2,...,62; beat 8 lane 0 = 1, lane 1 = 3; out_valid high exactly 16 cycles.
- Macro defined, perm_mode=1 -> beat 0 lane 0 = 0, lane 1 = 256; beat 1 lane 0 = 8; beat 15 lane 31 = 511.
- Two back-to-back frames (values i, then 1000+i) at t and t+16 -> out_valid high t+17..t+48 unbroken; out_start at t+17 and t+33; second frame beat 0 lane 1 = 1002.
- Spurious in_start at t+5 -> ignored; output identical to first scenario.
- rst at t+8 for 1 cycle -> out_valid never asserts for that frame, outputs 0; new frame at t+12 emerges correctly at t+29.
- Macro undefined, perm_mode=1 -> output identical to stride scenario.
